// File: rtl/bcd_scan_display_if.sv
// Display bus for bcd_scan_display.
// The master side supplies the BCD word, the decimal-point mask and the blanking control.
// The slave side (the scanner) returns the segment, decimal-point and anode drives,
// along with the frame-done strobe.
interface bcd_scan_display_if #(
    parameter int DIGITS = 6
);
    logic                  load;
    logic [DIGITS*4-1:0]   bcd_in;
    logic [DIGITS-1:0]     dp_mask;
    logic                  blank_lz;
    logic [6:0]            seg;
    logic                  dp;
    logic [DIGITS-1:0]     an;
    logic                  frame_done;

    modport master (
        output load, bcd_in, dp_mask, blank_lz,
        input  seg, dp, an, frame_done
    );

    modport slave (
        input  load, bcd_in, dp_mask, blank_lz,
        output seg, dp, an, frame_done
    );
endinterface

// File: rtl/bcd_scan_display.sv
// Time-multiplexed 7-segment scanner for a packed BCD word.
// The scanner shows one digit per scan slot. It supports leading-zero blanking
// and a decimal point for each digit. A newly loaded value is held in a pending
// register and becomes the displayed value only at a frame boundary, so a
// single frame never shows a mix of old and new digits.
module bcd_scan_display #(
    parameter int DIGITS         = 6,
    parameter int SCAN_DIV       = 5000,
    parameter bit SEG_ACTIVE_LOW = 1'b1,
    parameter bit AN_ACTIVE_LOW  = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst,
    bcd_scan_display_if.slave    bus
);
    localparam int PW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    // XOR masks that turn an active-high pattern into the pin polarity
    localparam logic [6:0]        SEG_OFF = {7{SEG_ACTIVE_LOW}};
    localparam logic              DP_OFF  = SEG_ACTIVE_LOW;
    localparam logic [DIGITS-1:0] AN_OFF  = {DIGITS{AN_ACTIVE_LOW}};

    // Active-high segment pattern (seg[0]=a .. seg[6]=g); non-decimal nibbles show a dash
    function automatic logic [6:0] decode_digit(input logic [3:0] nib);
        logic [6:0] pat;
        case (nib)
            4'd0:    pat = 7'h3F;
            4'd1:    pat = 7'h06;
            4'd2:    pat = 7'h5B;
            4'd3:    pat = 7'h4F;
            4'd4:    pat = 7'h66;
            4'd5:    pat = 7'h6D;
            4'd6:    pat = 7'h7D;
            4'd7:    pat = 7'h07;
            4'd8:    pat = 7'h7F;
            4'd9:    pat = 7'h6F;
            default: pat = 7'h40;
        endcase
        return pat;
    endfunction

    logic [PW-1:0]          prescale_r;
    logic [IW-1:0]          idx_r;
    logic [DIGITS*4-1:0]    disp_bcd_r;
    logic [DIGITS-1:0]      disp_dp_r;
    logic [DIGITS*4-1:0]    pend_bcd_r;
    logic [DIGITS-1:0]      pend_dp_r;
    logic                   pend_flag_r;
    logic [6:0]             seg_r;
    logic                   dp_r;
    logic [DIGITS-1:0]      an_r;
    logic                   frame_done_r;

    logic                   tick_s;
    logic                   last_digit_s;
    logic                   boundary_s;
    logic [3:0]             cur_nib_s;
    logic                   cur_dp_s;
    logic                   cur_zero_above_s;
    logic [DIGITS-1:0]      onehot_s;
    logic [DIGITS-1:0]      zero_above_s;
    logic                   zero_acc_s;
    logic                   blank_s;
    logic [6:0]             seg_lit_s;

    assign tick_s       = (prescale_r == PW'(SCAN_DIV - 1));
    assign last_digit_s = (idx_r == IW'(DIGITS - 1));
    assign boundary_s   = tick_s && last_digit_s;

    // Select the current digit and work out which digits sit above the last nonzero digit
    always_comb begin
        cur_nib_s        = 4'h0;
        cur_dp_s         = 1'b0;
        cur_zero_above_s = 1'b0;
        onehot_s         = {DIGITS{1'b0}};
        zero_above_s     = {DIGITS{1'b0}};
        zero_acc_s       = 1'b1;
        // Walk from the most significant digit down: each bit is set while all higher digits are zero
        for (int i = DIGITS - 1; i >= 0; i--) begin
            zero_acc_s      = zero_acc_s & (disp_bcd_r[i*4 +: 4] == 4'h0);
            zero_above_s[i] = zero_acc_s;
        end
        for (int i = 0; i < DIGITS; i++) begin
            if (idx_r == IW'(i)) begin
                cur_nib_s        = disp_bcd_r[i*4 +: 4];
                cur_dp_s         = disp_dp_r[i];
                cur_zero_above_s = zero_above_s[i];
                onehot_s[i]      = 1'b1;
            end else begin
                onehot_s[i]      = 1'b0;
            end
        end
        // Digit 0 always shows a digit, so a value of zero still displays "0"
        blank_s = bus.blank_lz && (idx_r != {IW{1'b0}}) && cur_zero_above_s;
        if (blank_s) begin
            seg_lit_s = 7'h00;
        end else begin
            seg_lit_s = decode_digit(cur_nib_s);
        end
    end

    // Scan-slot prescaler: counts from 0 to SCAN_DIV-1 and then wraps to 0
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prescale_r <= {PW{1'b0}};
        end else if (tick_s) begin
            prescale_r <= {PW{1'b0}};
        end else begin
            prescale_r <= prescale_r + PW'(1);
        end
    end

    // Digit index: advances once per slot and wraps after the most significant digit
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx_r <= {IW{1'b0}};
        end else if (tick_s) begin
            if (last_digit_s) begin
                idx_r <= {IW{1'b0}};
            end else begin
                idx_r <= idx_r + IW'(1);
            end
        end
    end

    // Capture loads into pending; promote pending to the display only at a frame boundary
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            disp_bcd_r  <= {(DIGITS*4){1'b0}};
            disp_dp_r   <= {DIGITS{1'b0}};
            pend_bcd_r  <= {(DIGITS*4){1'b0}};
            pend_dp_r   <= {DIGITS{1'b0}};
            pend_flag_r <= 1'b0;
        end else if (bus.load) begin
            pend_bcd_r <= bus.bcd_in;
            pend_dp_r  <= bus.dp_mask;
            if (boundary_s) begin
                // A load that coincides with the boundary is already frame-aligned
                disp_bcd_r  <= bus.bcd_in;
                disp_dp_r   <= bus.dp_mask;
                pend_flag_r <= 1'b0;
            end else begin
                pend_flag_r <= 1'b1;
            end
        end else if (boundary_s && pend_flag_r) begin
            disp_bcd_r  <= pend_bcd_r;
            disp_dp_r   <= pend_dp_r;
            pend_flag_r <= 1'b0;
        end
    end

    // Registered pin drives: update once per slot and hold for the rest of the slot
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            seg_r        <= SEG_OFF;
            dp_r         <= DP_OFF;
            an_r         <= AN_OFF;
            frame_done_r <= 1'b0;
        end else begin
            frame_done_r <= boundary_s;
            if (tick_s) begin
                seg_r <= seg_lit_s ^ SEG_OFF;
                dp_r  <= cur_dp_s ^ DP_OFF;
                an_r  <= onehot_s ^ AN_OFF;
            end
        end
    end

    assign bus.seg        = seg_r;
    assign bus.dp         = dp_r;
    assign bus.an         = an_r;
    assign bus.frame_done = frame_done_r;

endmodule

// File: tb/tb_bcd_scan_display.sv
// Scoreboard bench for bcd_scan_display (DIGITS=6, SCAN_DIV=4, active-low pins).
// The expected slot contents are queued when a scenario is set up. They are then
// popped and compared at each scan slot, sampled on the falling clock edge.
module tb_bcd_scan_display;
    localparam int DIGITS   = 6;
    localparam int SCAN_DIV = 4;

    typedef struct packed {
        logic [5:0] an;
        logic [6:0] seg;
        logic       dp;
        logic       fd;
    } slot_t;

    localparam slot_t RESET_SLOT = '{an: 6'h3F, seg: 7'h7F, dp: 1'b1, fd: 1'b0};

    logic  clk = 1'b0;
    logic  rst = 1'b1;
    slot_t exp_q[$];
    int    tests_run    = 0;
    int    tests_failed = 0;

    bcd_scan_display_if #(.DIGITS(DIGITS)) bus();

    bcd_scan_display #(
        .DIGITS(DIGITS),
        .SCAN_DIV(SCAN_DIV),
        .SEG_ACTIVE_LOW(1'b1),
        .AN_ACTIVE_LOW(1'b1)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    // Active-low segment patterns as seen on the pins
    function automatic logic [6:0] seg_low(input logic [3:0] n);
        logic [6:0] s;
        case (n)
            4'd0:    s = 7'h40;
            4'd1:    s = 7'h79;
            4'd2:    s = 7'h24;
            4'd3:    s = 7'h30;
            4'd4:    s = 7'h19;
            4'd5:    s = 7'h12;
            4'd6:    s = 7'h02;
            4'd7:    s = 7'h78;
            4'd8:    s = 7'h00;
            4'd9:    s = 7'h10;
            default: s = 7'h3F;
        endcase
        return s;
    endfunction

    function automatic slot_t mk_slot(input logic [23:0] val, input logic [5:0] dpm,
                                      input logic blk, input int d);
        slot_t      s;
        logic [5:0] one;
        one   = 6'b000001 << d;
        s.an  = ~one;
        s.seg = (blk && d > 0 && ((val >> (4 * d)) == 24'h0)) ? 7'h7F : seg_low(val[d*4 +: 4]);
        s.dp  = ~dpm[d];
        s.fd  = (d == DIGITS - 1);
        return s;
    endfunction

    function automatic void push_frame(input logic [23:0] val, input logic [5:0] dpm, input logic blk);
        for (int d = 0; d < DIGITS; d++) exp_q.push_back(mk_slot(val, dpm, blk, d));
    endfunction

    function automatic slot_t observe();
        slot_t o;
        o.an  = bus.an;
        o.seg = bus.seg;
        o.dp  = bus.dp;
        o.fd  = bus.frame_done;
        return o;
    endfunction

    // Advance one scan slot; optionally pulse load for one cycle at the given cycle offset
    task automatic step_slot(input int load_cycle);
        for (int c = 0; c < SCAN_DIV; c++) begin
            if (c == load_cycle) bus.load = 1'b1;
            @(posedge clk);
            @(negedge clk);
            bus.load = 1'b0;
        end
    endtask

    task automatic test_reset();
        slot_t o;
        rst = 1'b1;
        bus.load = 1'b0; bus.bcd_in = 24'h0; bus.dp_mask = 6'h0; bus.blank_lz = 1'b0;
        repeat (3) @(negedge clk);
        o = observe();
        tests_run++;
        if (o !== RESET_SLOT) begin
            tests_failed++;
            $display("FAIL reset_state: got %h want %h (an,seg,dp,fd)", o, RESET_SLOT);
        end
        rst = 1'b0;
        for (int c = 0; c < SCAN_DIV; c++) begin
            o = observe();
            tests_run++;
            if (o !== RESET_SLOT) begin
                tests_failed++;
                $display("FAIL pre_first_tick cyc %0d: got %h want %h", c, o, RESET_SLOT);
            end
            @(posedge clk);
            @(negedge clk);
        end
    endtask

    task automatic test_scan();
        slot_t e, o;
        bus.blank_lz = 1'b0;
        push_frame(24'h0, 6'h0, 1'b0);
        for (int k = 0; k < DIGITS; k++) begin
            e = exp_q.pop_front();
            o = observe();
            tests_run++;
            if (o !== e) begin
                tests_failed++;
                $display("FAIL scan slot %0d: got %h want %h", k, o, e);
            end
            @(posedge clk);
            @(negedge clk);
            tests_run++;
            if (bus.frame_done !== 1'b0 || bus.an !== e.an) begin
                tests_failed++;
                $display("FAIL scan_hold slot %0d: got an=%h fd=%b want an=%h fd=0", k, bus.an, bus.frame_done, e.an);
            end
            repeat (SCAN_DIV - 1) begin
                @(posedge clk);
                @(negedge clk);
            end
        end
    endtask

    task automatic test_blanking();
        slot_t e, o;
        bus.blank_lz = 1'b1;
        bus.bcd_in   = 24'h000123;
        bus.dp_mask  = 6'b010010;
        push_frame(24'h0, 6'h0, 1'b1);
        push_frame(24'h000123, 6'b010010, 1'b1);
        for (int k = 0; k < 2 * DIGITS; k++) begin
            e = exp_q.pop_front();
            o = observe();
            tests_run++;
            if (o !== e) begin
                tests_failed++;
                $display("FAIL blanking slot %0d: got %h want %h", k, o, e);
            end
            step_slot(k == 0 ? 0 : -1);
        end
    endtask

    task automatic test_dash();
        slot_t e, o;
        bus.blank_lz = 1'b0;
        bus.bcd_in   = 24'h00A000;
        bus.dp_mask  = 6'h0;
        push_frame(24'h000123, 6'b010010, 1'b0);
        push_frame(24'h00A000, 6'h0, 1'b0);
        for (int k = 0; k < 2 * DIGITS; k++) begin
            e = exp_q.pop_front();
            o = observe();
            tests_run++;
            if (o !== e) begin
                tests_failed++;
                $display("FAIL dash slot %0d: got %h want %h", k, o, e);
            end
            step_slot(k == 0 ? 1 : -1);
        end
    endtask

    task automatic test_midframe();
        slot_t e, o;
        bus.bcd_in = 24'h111111;
        push_frame(24'h00A000, 6'h0, 1'b0);
        push_frame(24'h111111, 6'h0, 1'b0);
        for (int k = 0; k < 2 * DIGITS; k++) begin
            e = exp_q.pop_front();
            o = observe();
            tests_run++;
            if (o !== e) begin
                tests_failed++;
                $display("FAIL midframe slot %0d: got %h want %h", k, o, e);
            end
            step_slot(k == 2 ? 1 : -1);
        end
    endtask

    task automatic test_back_to_back();
        slot_t e, o;
        push_frame(24'h111111, 6'h0, 1'b0);
        push_frame(24'h999999, 6'h0, 1'b0);
        push_frame(24'h999999, 6'h0, 1'b0);
        for (int k = 0; k < 3 * DIGITS; k++) begin
            e = exp_q.pop_front();
            o = observe();
            tests_run++;
            if (o !== e) begin
                tests_failed++;
                $display("FAIL boundary_load slot %0d: got %h want %h", k, o, e);
            end
            if (k == 1) begin
                bus.bcd_in  = 24'h222222;
                bus.dp_mask = 6'h3F;
                step_slot(2);
            end else if (k == 4) begin
                bus.bcd_in  = 24'h999999;
                bus.dp_mask = 6'h0;
                step_slot(SCAN_DIV - 1);
            end else begin
                step_slot(-1);
            end
        end
    endtask

    task automatic test_async_reset();
        slot_t e, o;
        for (int d = 0; d < 3; d++) exp_q.push_back(mk_slot(24'h999999, 6'h0, 1'b0, d));
        for (int k = 0; k < 3; k++) begin
            e = exp_q.pop_front();
            o = observe();
            tests_run++;
            if (o !== e) begin
                tests_failed++;
                $display("FAIL pre_reset slot %0d: got %h want %h", k, o, e);
            end
            if (k < 2) step_slot(-1);
        end
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        o = observe();
        tests_run++;
        if (o !== RESET_SLOT) begin
            tests_failed++;
            $display("FAIL async_reset: got %h want %h", o, RESET_SLOT);
        end
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < SCAN_DIV; c++) begin
            o = observe();
            tests_run++;
            if (o !== RESET_SLOT) begin
                tests_failed++;
                $display("FAIL post_reset_idle cyc %0d: got %h want %h", c, o, RESET_SLOT);
            end
            @(posedge clk);
            @(negedge clk);
        end
        push_frame(24'h0, 6'h0, 1'b0);
        for (int k = 0; k < DIGITS; k++) begin
            e = exp_q.pop_front();
            o = observe();
            tests_run++;
            if (o !== e) begin
                tests_failed++;
                $display("FAIL post_reset slot %0d: got %h want %h", k, o, e);
            end
            step_slot(-1);
        end
    endtask

    initial begin
        test_reset();
        test_scan();
        test_blanking();
        test_dash();
        test_midframe();
        test_back_to_back();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
